// File: rtl/riscv_dmem_ctrl_if.sv
// Load/store request/response channel and data-SRAM port of the RISC-V data-memory controller.
interface riscv_dmem_ctrl_if #(
  parameter int DMEM_ADDR_BIT = 10
);
  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_wr;
  logic [31:0]              i_req_addr;
  logic [3:0]               i_req_byte_sel;
  logic                     i_req_unsigned;
  logic [31:0]              i_req_wdata;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [31:0]              o_rsp_rdata;
  logic                     o_rsp_err;
  logic                     o_mem_cs;
  logic                     o_mem_we;
  logic [DMEM_ADDR_BIT-1:0] o_mem_addr;
  logic [3:0]               o_mem_be;
  logic [31:0]              o_mem_wdata;
  logic [31:0]              i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_byte_sel, i_req_unsigned, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_cs, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_byte_sel, i_req_unsigned, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_cs, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Single-outstanding RISC-V load/store unit: alignment check, lane steering to a
// 1-cycle-latency SRAM, and load extraction with sign/zero extension.
module riscv_dmem_ctrl #(
  parameter int DMEM_ADDR_BIT = 10
) (
  input logic               i_clk,
  input logic               i_rstn,
  riscv_dmem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

  state_e                   state_q, state_d;
  logic [DMEM_ADDR_BIT-1:0] waddr_q, waddr_d;
  logic [1:0]               off_q, off_d;
  logic                     wr_q, wr_d;
  logic [3:0]               bsel_q, bsel_d;
  logic                     uns_q, uns_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                     req_err;
  logic [31:0]              mem_sh;
  logic                     unused_addr;

  assign unused_addr = ^bus.i_req_addr[31:DMEM_ADDR_BIT+2];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      wr_q    <= 1'b0;
      bsel_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      bsel_q  <= bsel_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (bus.i_req_byte_sel)
      4'b0001: req_err = 1'b0;
      4'b0011: req_err = bus.i_req_addr[0];
      4'b1111: req_err = |bus.i_req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    mem_sh  = bus.i_mem_rdata >> {off_q, 3'b000};
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    wr_d    = wr_q;
    bsel_d  = bsel_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.i_req_valid) begin
        waddr_d = bus.i_req_addr[DMEM_ADDR_BIT+1:2];
        off_d   = bus.i_req_addr[1:0];
        wr_d    = bus.i_req_wr;
        bsel_d  = bus.i_req_byte_sel;
        uns_d   = bus.i_req_unsigned;
        wdata_d = bus.i_req_wdata;
        // Clearing here makes store and error responses carry zero data.
        rdata_d = '0;
        err_d   = req_err;
        state_d = req_err ? RESP : ACCESS;
      end
      ACCESS:  state_d = wr_q ? RESP : CAPTURE;
      CAPTURE: begin
        case (bsel_q)
          4'b0001: rdata_d = {{24{~uns_q & mem_sh[7]}}, mem_sh[7:0]};
          4'b0011: rdata_d = {{16{~uns_q & mem_sh[15]}}, mem_sh[15:0]};
          default: rdata_d = mem_sh;
        endcase
        state_d = RESP;
      end
      RESP:    if (bus.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  assign bus.o_mem_cs    = (state_q == ACCESS);
  assign bus.o_mem_we    = (state_q == ACCESS) & wr_q;
  assign bus.o_mem_be    = (state_q == ACCESS) ? 4'(bsel_q << off_q) : 4'b0000;
  assign bus.o_mem_addr  = waddr_q;
  assign bus.o_mem_wdata = wdata_q << {off_q, 3'b000};
endmodule
